// File: rtl/mac_pipe.sv
// Pipelined unsigned multiply-accumulate with valid/ready on both sides.
// One global advance signal moves every stage; arithmetic happens as a beat enters the output register.
module mac_pipe #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16,
   parameter int PIPE_STAGES  = 3,
   parameter int SATURATE     = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INPUT_WIDTH-1:0]  in0,
   input  logic [INPUT_WIDTH-1:0]  in1,
   input  logic                    in_acc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out,
   output logic                    out_ovf
);

   localparam int NS = PIPE_STAGES - 1;
   localparam int PW = 2 * INPUT_WIDTH;
   localparam int SW = ((PW > OUTPUT_WIDTH) ? PW : OUTPUT_WIDTH) + 1;

   logic                    adv;
   logic [NS-1:0]           v_q, v_d;
   logic [NS-1:0]           mode_q, mode_d;
   logic [INPUT_WIDTH-1:0]  a_q [NS];
   logic [INPUT_WIDTH-1:0]  a_d [NS];
   logic [INPUT_WIDTH-1:0]  b_q [NS];
   logic [INPUT_WIDTH-1:0]  b_d [NS];
   logic                    out_valid_q, out_valid_d;
   logic [OUTPUT_WIDTH-1:0] out_q, out_d;
   logic                    ovf_q, ovf_d;
   logic [OUTPUT_WIDTH-1:0] accum_q, accum_d;

   logic [PW-1:0]           prod;
   logic [SW-1:0]           sum;
   logic                    ovf_c;
   logic [OUTPUT_WIDTH-1:0] res;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      prod  = PW'(a_q[NS-1]) * PW'(b_q[NS-1]);
      sum   = SW'(prod) + (mode_q[NS-1] ? SW'(accum_q) : SW'(0));
      ovf_c = |sum[SW-1:OUTPUT_WIDTH];
      res   = (ovf_c && (SATURATE != 0)) ? {OUTPUT_WIDTH{1'b1}}
                                         : sum[OUTPUT_WIDTH-1:0];

      v_d         = v_q;
      mode_d      = mode_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      accum_d     = accum_q;

      if (adv) begin
         v_d[0]    = in_valid;
         mode_d[0] = in_acc;
         a_d[0]    = in0;
         b_d[0]    = in1;
         for (int i = 1; i < NS; i++) begin
            v_d[i]    = v_q[i-1];
            mode_d[i] = mode_q[i-1];
            a_d[i]    = a_q[i-1];
            b_d[i]    = b_q[i-1];
         end
         out_valid_d = v_q[NS-1];
         // Bubbles leave result and accumulator untouched
         if (v_q[NS-1]) begin
            out_d   = res;
            ovf_d   = ovf_c;
            accum_d = res;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v_q         <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         accum_q     <= '0;
      end else begin
         v_q         <= v_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         accum_q     <= accum_d;
      end
   end

   always_ff @(posedge clock) begin
      a_q <= a_d;
      b_q <= b_d;
   end

endmodule
